// File: rtl/adder_subtractor.sv
// ---------------------------------------------------------------------------
// adder_subtractor
//
// Purpose:
//   Registered n-bit two's-complement adder/subtractor. add_n selects x+y
//   (add_n=0) or x-y (add_n=1). The sum/difference, the raw carry out of the
//   top bit and the signed overflow flag are registered and appear one clock
//   after a valid input, qualified by a single-cycle out_valid pulse.
//
// Parameters:
//   n          operand/result width in bits (n >= 2), default 4
//
// Ports:
//   clk        in   1  sole clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   in_valid   in   1  x, y, add_n are sampled on this edge when high
//   x          in   n  operand A, two's complement
//   y          in   n  operand B, two's complement
//   add_n      in   1  0 = add, 1 = subtract
//   s          out  n  registered result (low n bits)
//   c_out      out  1  registered raw carry out of bit n-1
//                      (for subtract: 1 = no borrow, 0 = borrow)
//   overflow   out  1  registered signed overflow
//   out_valid  out  1  high for one cycle when s/c_out/overflow update
//
// Build options:
//   ADDSUB_SAT_EN  when defined, s saturates to the most positive or most
//                  negative value on signed overflow instead of wrapping.
//                  c_out and overflow always report the raw values.
// ---------------------------------------------------------------------------
module adder_subtractor #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out,
  output logic         overflow,
  output logic         out_valid
);

  // Effective second operand: y for add, ~y for subtract. The "+1" that
  // completes the two's-complement negation enters as the carry-in.
  logic [n-1:0] yy;

  // carry[i] is the carry into bit i; carry[n] is the carry out of bit n-1.
  logic [n:0]   carry;
  logic [n-1:0] raw_sum;
  logic         raw_overflow;
  logic [n-1:0] next_s;

  // Conditionally invert y so one adder serves both operations.
  always_comb begin
    yy = add_n ? ~y : y;
  end

  assign carry[0] = add_n;

  // Explicit ripple chain so the carry into the sign bit is available
  // directly; overflow is defined in terms of that carry.
  generate
    for (genvar i = 0; i < n; i++) begin : g_bit
      assign raw_sum[i]   = x[i] ^ yy[i] ^ carry[i];
      assign carry[i + 1] = (x[i] & yy[i]) | (carry[i] & (x[i] ^ yy[i]));
    end
  endgenerate

  // Signed overflow: the carry into the sign bit disagrees with the carry
  // out of it, i.e. both effective operands share a sign the result lacks.
  assign raw_overflow = carry[n] ^ carry[n - 1];

`ifdef ADDSUB_SAT_EN
  localparam logic [n-1:0] sat_max = {1'b0, {(n - 1){1'b1}}};
  localparam logic [n-1:0] sat_min = {1'b1, {(n - 1){1'b0}}};

  // On overflow both effective operands have the same sign, so x's sign
  // tells us which way the true result went: positive clamps to max,
  // negative clamps to min.
  always_comb begin
    next_s = raw_sum;
    if (raw_overflow) begin
      next_s = x[n - 1] ? sat_min : sat_max;
    end
  end
`else
  // Without saturation the result simply wraps modulo 2^n.
  always_comb begin
    next_s = raw_sum;
  end
`endif

  // Output register. Reset dominates any simultaneous valid input, so an
  // operation presented during reset is dropped. With no valid input the
  // result registers hold their last value and only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s        <= next_s;
        c_out    <= carry[n];
        overflow <= raw_overflow;
      end
    end
  end

endmodule

// File: tb/tb_adder_subtractor.sv
// ---------------------------------------------------------------------------
// tb_adder_subtractor
//
// Self-checking bench for adder_subtractor at n=4. Expected results come from
// an integer arithmetic model, are queued when an operation is driven and
// popped when the design should present its output one cycle later. Cycles
// with nothing queued expect out_valid=0 and the previous outputs held.
// ---------------------------------------------------------------------------
module tb_adder_subtractor;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         add_n;
  logic [N-1:0] s;
  logic         c_out;
  logic         overflow;
  logic         out_valid;

  exp_t         exp_q[$];
  logic [N-1:0] last_s;
  logic         last_c;
  logic         last_ov;
  int           checks;
  int           errors;

  adder_subtractor #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .add_n     (add_n),
    .s         (s),
    .c_out     (c_out),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model using plain integer arithmetic on the signed and
  // unsigned interpretations of the operands.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic sub);
    exp_t r;
    int   as_v;
    int   bs_v;
    int   au_v;
    int   bu_v;
    int   true_v;
    as_v   = $signed(a);
    bs_v   = $signed(b);
    au_v   = int'(a);
    bu_v   = int'(b);
    true_v = sub ? (as_v - bs_v) : (as_v + bs_v);
    r.s    = true_v[N-1:0];
    r.c    = sub ? (au_v >= bu_v) : ((au_v + bu_v) > 15);
    r.ov   = (true_v > 7) || (true_v < -8);
`ifdef ADDSUB_SAT_EN
    if (r.ov) r.s = (true_v > 0) ? 4'h7 : 4'h8;
`endif
    return r;
  endfunction

  // Single comparison point: counts, asserts, reports on failure.
  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation for the coming edge and queue its expected result.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic sub);
    in_valid = 1'b1;
    x        = a;
    y        = b;
    add_n    = sub;
    exp_q.push_back(model(a, b, sub));
  endtask

  // Compare outputs after an edge: pop a queued result if one is due,
  // otherwise expect no valid and held outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkValue({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      checkValue({tag, ".s"},         32'(s),         32'(e.s));
      checkValue({tag, ".c_out"},     32'(c_out),     32'(e.c));
      checkValue({tag, ".overflow"},  32'(overflow),  32'(e.ov));
      last_s  = e.s;
      last_c  = e.c;
      last_ov = e.ov;
    end else begin
      checkValue({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      checkValue({tag, ".s_hold"},    32'(s),         32'(last_s));
      checkValue({tag, ".c_hold"},    32'(c_out),     32'(last_c));
      checkValue({tag, ".ov_hold"},   32'(overflow),  32'(last_ov));
    end
  endtask

  // One operation followed by its check on the next falling edge.
  task automatic runOp(input string tag, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic sub);
    applyStimulus(a, b, sub);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput(tag);
  endtask

  task automatic idleCycle(input string tag);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput(tag);
  endtask

  // Reset together with a valid input: the op must be dropped.
  task automatic resetWithOp(input string tag);
    rst      = 1'b1;
    in_valid = 1'b1;
    x        = 4'h5;
    y        = 4'h6;
    add_n    = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    last_s   = '0;
    last_c   = 1'b0;
    last_ov  = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    add_n    = 1'b0;
    last_s   = '0;
    last_c   = 1'b0;
    last_ov  = 1'b0;

    resetWithOp("reset");

    runOp("5+6",   4'h5, 4'h6, 1'b0);
    runOp("5-6",   4'h5, 4'h6, 1'b1);
    runOp("6-(-3)", 4'h6, 4'hD, 1'b1);
    runOp("-4+-5", 4'hC, 4'hB, 1'b0);
    runOp("3-3",   4'h3, 4'h3, 1'b1);
    runOp("min+min", 4'h8, 4'h8, 1'b0);
    runOp("0-min", 4'h0, 4'h8, 1'b1);
    runOp("7-7",   4'h7, 4'h7, 1'b1);
    runOp("1+2",   4'h1, 4'h2, 1'b0);

    // Idle cycles: outputs hold the last result.
    idleCycle("hold1");
    idleCycle("hold2");

    // Back-to-back operations, one result per cycle.
    applyStimulus(4'h2, 4'h3, 1'b0);
    @(negedge clk);
    checkOutput("b2b0");
    applyStimulus(4'h7, 4'h1, 1'b0);
    @(negedge clk);
    checkOutput("b2b1");
    applyStimulus(4'h9, 4'h4, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("b2b2");

    // Random back-to-back stream.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)),
                    1'($urandom_range(1)));
      @(negedge clk);
      checkOutput("rand");
    end
    in_valid = 1'b0;
    idleCycle("rand_end");

    // Reset while valid, then outputs stay at zero through idle cycles.
    resetWithOp("reset_mid");
    idleCycle("rst_hold1");
    idleCycle("rst_hold2");
    idleCycle("rst_hold3");

    // Operation after reset, then it holds.
    runOp("post_rst", 4'h4, 4'h5, 1'b0);
    idleCycle("post_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
